// File: rtl/sensor_seq_gen.sv
// Emits entry (10,11,01,00) or exit (01,11,10,00) phase sequences on a/b, each phase held HOLD_CYCLES; start->P1 in 1 cycle.
// One-deep pending slot absorbs a start while busy (ready drops); further starts are dropped until it launches.
module sensor_seq_gen #(
  parameter int HOLD_CYCLES = 1,
  parameter int CNT_W       = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             dir,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic             a,
  output logic             b,
  output logic [CNT_W-1:0] enter_sent,
  output logic [CNT_W-1:0] exit_sent
);

  localparam int HW = $clog2(HOLD_CYCLES + 1);
  localparam logic [HW-1:0] HOLD_LD = HW'(HOLD_CYCLES - 1);
  localparam logic [HW-1:0] HOLD_ONE = HW'(1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_P1   = 3'd1,
    S_P2   = 3'd2,
    S_P3   = 3'd3,
    S_P4   = 3'd4
  } state_t;

  state_t          state, nxt_state;
  logic [HW-1:0]   hold_cnt, nxt_cnt;
  logic            cur_dir, nxt_dir;
  logic            pend_vld, nxt_pend_vld;
  logic            pend_dir, nxt_pend_dir;
  logic            phase_end;
  logic            seq_end;

  // Line pattern for a phase; direction only swaps which beam leads and trails.
  function automatic logic [1:0] phase_ab(input state_t s, input logic d);
    case (s)
      S_P1:    phase_ab = d ? 2'b01 : 2'b10;
      S_P2:    phase_ab = 2'b11;
      S_P3:    phase_ab = d ? 2'b10 : 2'b01;
      default: phase_ab = 2'b00;
    endcase
  endfunction

  always_comb begin
    nxt_state    = state;
    nxt_dir      = cur_dir;
    nxt_pend_vld = pend_vld;
    nxt_pend_dir = pend_dir;
    phase_end    = (hold_cnt == '0);
    seq_end      = 1'b0;
    nxt_cnt      = phase_end ? hold_cnt : hold_cnt - HOLD_ONE;

    if (state inside {S_P1, S_P2, S_P3, S_P4} && start && !pend_vld) begin
      nxt_pend_vld = 1'b1;
      nxt_pend_dir = dir;
    end

    case (state)
      S_IDLE: begin
        if (start) begin
          nxt_state = S_P1;
          nxt_dir   = dir;
          nxt_cnt   = HOLD_LD;
        end
      end
      S_P1: begin
        if (phase_end) begin
          nxt_state = S_P2;
          nxt_cnt   = HOLD_LD;
        end
      end
      S_P2: begin
        if (phase_end) begin
          nxt_state = S_P3;
          nxt_cnt   = HOLD_LD;
        end
      end
      S_P3: begin
        if (phase_end) begin
          nxt_state = S_P4;
          nxt_cnt   = HOLD_LD;
        end
      end
      S_P4: begin
        if (phase_end) begin
          seq_end = 1'b1;
          // A start landing in the last P4 cycle launches straight away, same as a pending one.
          if (pend_vld) begin
            nxt_state    = S_P1;
            nxt_dir      = pend_dir;
            nxt_cnt      = HOLD_LD;
            nxt_pend_vld = 1'b0;
          end else if (start) begin
            nxt_state    = S_P1;
            nxt_dir      = dir;
            nxt_cnt      = HOLD_LD;
            nxt_pend_vld = 1'b0;
          end else begin
            nxt_state = S_IDLE;
          end
        end
      end
      default: begin
        nxt_state    = S_IDLE;
        nxt_cnt      = '0;
        nxt_pend_vld = 1'b0;
      end
    endcase
  end

  // Outputs are flops loaded from next-state so they line up with the state they describe.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= S_IDLE;
      hold_cnt   <= '0;
      cur_dir    <= 1'b0;
      pend_vld   <= 1'b0;
      pend_dir   <= 1'b0;
      a          <= 1'b0;
      b          <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      ready      <= 1'b1;
      enter_sent <= '0;
      exit_sent  <= '0;
    end else begin
      state    <= nxt_state;
      hold_cnt <= nxt_cnt;
      cur_dir  <= nxt_dir;
      pend_vld <= nxt_pend_vld;
      pend_dir <= nxt_pend_dir;
      {a, b}   <= phase_ab(nxt_state, nxt_dir);
      busy     <= (nxt_state != S_IDLE);
      done     <= (nxt_state == S_P4) && (nxt_cnt == '0);
      ready    <= !nxt_pend_vld;
      if (seq_end) begin
        if (cur_dir) exit_sent  <= exit_sent + CNT_ONE;
        else         enter_sent <= enter_sent + CNT_ONE;
      end
    end
  end

endmodule

// File: tb/tb_sensor_seq_gen.sv
// Bench for sensor_seq_gen: two instances (HOLD 1/CNT_W 8 and HOLD 3/CNT_W 2) against a timeline model.
module tb_sensor_seq_gen;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] st  = 2'b00;
  logic [1:0] dr  = 2'b00;
  logic [1:0] rdy, bsy, dn, ao, bo;
  logic [7:0] ent0, ext0;
  logic [1:0] ent1, ext1;

  int checks = 0;
  int errs   = 0;

  always #5 clk = ~clk;

  sensor_seq_gen #(.HOLD_CYCLES(1), .CNT_W(8)) dut0 (
    .clk(clk), .reset(rst), .start(st[0]), .dir(dr[0]),
    .ready(rdy[0]), .busy(bsy[0]), .done(dn[0]), .a(ao[0]), .b(bo[0]),
    .enter_sent(ent0), .exit_sent(ext0)
  );

  sensor_seq_gen #(.HOLD_CYCLES(3), .CNT_W(2)) dut1 (
    .clk(clk), .reset(rst), .start(st[1]), .dir(dr[1]),
    .ready(rdy[1]), .busy(bsy[1]), .done(dn[1]), .a(ao[1]), .b(bo[1]),
    .enter_sent(ent1), .exit_sent(ext1)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
    checks++;
    if (act !== want) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, want, $time);
    end
  endtask

  function automatic int hold_of(input int k);
    return (k == 0) ? 1 : 3;
  endfunction

  function automatic int cnt_mod(input int k);
    return (k == 0) ? 256 : 4;
  endfunction

  function automatic logic [1:0] seq_ab(input logic d, input int ph);
    logic [1:0] ent_tab [4];
    logic [1:0] ext_tab [4];
    ent_tab = '{2'b10, 2'b11, 2'b01, 2'b00};
    ext_tab = '{2'b01, 2'b11, 2'b10, 2'b00};
    return d ? ext_tab[ph] : ent_tab[ph];
  endfunction

  // Model: a sequence is a 4*HOLD-cycle window; position in it determines the lines.
  logic m_act [2] = '{1'b0, 1'b0};
  logic m_dir [2] = '{1'b0, 1'b0};
  logic m_pv  [2] = '{1'b0, 1'b0};
  logic m_pd  [2] = '{1'b0, 1'b0};
  int   m_t   [2] = '{0, 0};
  int   m_ent [2] = '{0, 0};
  int   m_ext [2] = '{0, 0};

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < 2; k++) begin
        m_act[k] <= 1'b0; m_pv[k] <= 1'b0; m_t[k] <= 0;
        m_ent[k] <= 0;    m_ext[k] <= 0;
      end
    end else begin
      for (int k = 0; k < 2; k++) begin
        if (m_act[k] && m_t[k] == 4 * hold_of(k) - 1) begin
          if (m_dir[k]) m_ext[k] <= m_ext[k] + 1;
          else          m_ent[k] <= m_ent[k] + 1;
          m_t[k] <= 0;
          if (m_pv[k]) begin
            m_dir[k] <= m_pd[k];
            m_pv[k]  <= 1'b0;
          end else if (st[k]) begin
            m_dir[k] <= dr[k];
          end else begin
            m_act[k] <= 1'b0;
          end
        end else if (m_act[k]) begin
          m_t[k] <= m_t[k] + 1;
          if (st[k] && !m_pv[k]) begin
            m_pv[k] <= 1'b1;
            m_pd[k] <= dr[k];
          end
        end else if (st[k]) begin
          m_act[k] <= 1'b1;
          m_t[k]   <= 0;
          m_dir[k] <= dr[k];
        end
      end
    end
  end

  // Continuous compare, once per cycle on the falling edge.
  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      logic [1:0] w_ab;
      logic [4:0] want, act;
      int a_ent, a_ext;
      w_ab = m_act[k] ? seq_ab(m_dir[k], m_t[k] / hold_of(k)) : 2'b00;
      want = {w_ab, m_act[k], m_act[k] && (m_t[k] == 4 * hold_of(k) - 1), !m_pv[k]};
      act  = {ao[k], bo[k], bsy[k], dn[k], rdy[k]};
      a_ent = (k == 0) ? int'(ent0) : int'(ent1);
      a_ext = (k == 0) ? int'(ext0) : int'(ext1);
      chk($sformatf("model%0d ab/busy/done/ready", k), 32'(act), 32'(want));
      chk($sformatf("model%0d enter_sent", k), a_ent, m_ent[k] % cnt_mod(k));
      chk($sformatf("model%0d exit_sent", k), a_ext, m_ext[k] % cnt_mod(k));
    end
  end

  // Independent detector on dut0 lines: a full ordered 3-phase excursion back to 00 counts.
  logic [1:0] d_prev = 2'b00;
  logic [1:0] d_hist [$];
  int det_ent = 0, det_ext = 0;
  always @(negedge clk) begin
    logic [1:0] cur;
    cur = {ao[0], bo[0]};
    if (rst) begin
      d_prev = 2'b00;
      d_hist.delete();
    end else if (cur != d_prev) begin
      if (cur == 2'b00) begin
        if (d_hist.size() == 3 && d_hist[0] == 2'b10 && d_hist[1] == 2'b11 && d_hist[2] == 2'b01)
          det_ent++;
        else if (d_hist.size() == 3 && d_hist[0] == 2'b01 && d_hist[1] == 2'b11 && d_hist[2] == 2'b10)
          det_ext++;
        d_hist.delete();
      end else begin
        d_hist.push_back(cur);
      end
      d_prev = cur;
    end
  end

  task automatic tick;
    @(negedge clk);
    #1;
  endtask

  task automatic issue(input int k, input logic d);
    int n;
    n = 0;
    while (!rdy[k] && n < 200) begin tick(); n++; end
    if (n >= 200) chk("issue ready timeout", 1, 0);
    st[k] = 1'b1;
    dr[k] = d;
    tick();
    st[k] = 1'b0;
  endtask

  task automatic wait_idle(input int k);
    int n;
    n = 0;
    while (bsy[k] && n < 400) begin tick(); n++; end
    if (n >= 400) chk("busy timeout", 1, 0);
  endtask

  task automatic pulse_reset;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
  endtask

  initial begin
    logic [1:0] ent_tab [4];
    logic [1:0] ext_tab [4];
    int wrap_tab [5];
    int base_e, base_x;
    ent_tab  = '{2'b10, 2'b11, 2'b01, 2'b00};
    ext_tab  = '{2'b01, 2'b11, 2'b10, 2'b00};
    wrap_tab = '{1, 2, 3, 0, 1};

    // Reset state
    tick(); tick();
    chk("reset ready", 32'(rdy), 3);
    chk("reset busy", 32'(bsy), 0);
    chk("reset done", 32'(dn), 0);
    chk("reset lines", 32'({ao, bo}), 0);
    chk("reset counters", 32'({ent0, ext0, ent1, ext1}), 0);
    rst = 1'b0;
    tick();

    // Single entry, HOLD=1
    st[0] = 1'b1; dr[0] = 1'b0;
    for (int c = 1; c <= 5; c++) begin
      tick();
      if (c == 1) st[0] = 1'b0;
      if (c <= 4) begin
        chk($sformatf("entry ab c%0d", c), 32'({ao[0], bo[0]}), 32'(ent_tab[c-1]));
        chk($sformatf("entry done c%0d", c), 32'(dn[0]), (c == 4) ? 1 : 0);
      end else begin
        chk("entry busy after", 32'(bsy[0]), 0);
        chk("entry enter_sent", 32'(ent0), 1);
      end
    end

    // Single exit, HOLD=3
    st[1] = 1'b1; dr[1] = 1'b1;
    for (int c = 1; c <= 13; c++) begin
      tick();
      if (c == 1) st[1] = 1'b0;
      if (c <= 12) begin
        chk($sformatf("exit3 ab c%0d", c), 32'({ao[1], bo[1]}), 32'(ext_tab[(c-1)/3]));
        chk($sformatf("exit3 done c%0d", c), 32'(dn[1]), (c == 12) ? 1 : 0);
      end else begin
        chk("exit3 busy after", 32'(bsy[1]), 0);
        chk("exit3 exit_sent", 32'(ext1), 1);
      end
    end

    // Back-to-back with pending and a dropped third start
    st[0] = 1'b1; dr[0] = 1'b0;
    for (int c = 1; c <= 9; c++) begin
      tick();
      if (c == 1) st[0] = 1'b0;
      if (c == 2) begin st[0] = 1'b1; dr[0] = 1'b1; end
      if (c == 3) begin st[0] = 1'b1; dr[0] = 1'b0; end
      if (c == 4) st[0] = 1'b0;
      if (c <= 8) chk($sformatf("b2b busy c%0d", c), 32'(bsy[0]), 1);
      if (c == 3) chk("b2b ready pending", 32'(rdy[0]), 0);
      if (c == 5) chk("b2b exit P1", 32'({ao[0], bo[0]}), 32'(2'b01));
      if (c == 9) begin
        chk("b2b idle", 32'(bsy[0]), 0);
        chk("b2b enter_sent", 32'(ent0), 2);
        chk("b2b exit_sent", 32'(ext0), 1);
      end
    end

    // Reset during P3 of an exit
    st[1] = 1'b1; dr[1] = 1'b1;
    for (int c = 1; c <= 8; c++) begin
      tick();
      if (c == 1) st[1] = 1'b0;
    end
    chk("mid P3 lines", 32'({ao[1], bo[1]}), 32'(2'b10));
    rst = 1'b1;
    #1;
    chk("async rst lines", 32'({ao, bo}), 0);
    chk("async rst busy", 32'(bsy), 0);
    chk("async rst ready", 32'(rdy), 3);
    chk("async rst done", 32'(dn), 0);
    chk("async rst counters", 32'({ent0, ext0, ent1, ext1}), 0);
    tick();
    rst = 1'b0;
    tick();
    st[1] = 1'b1; dr[1] = 1'b0;
    tick();
    st[1] = 1'b0;
    chk("post-rst P1", 32'({ao[1], bo[1], bsy[1]}), 32'(3'b101));
    wait_idle(1);

    // Loop-back: 5 entries then 3 exits, back-to-back
    pulse_reset();
    base_e = det_ent;
    base_x = det_ext;
    for (int i = 0; i < 5; i++) issue(0, 1'b0);
    for (int i = 0; i < 3; i++) issue(0, 1'b1);
    wait_idle(0);
    tick();
    chk("detector entries", det_ent - base_e, 5);
    chk("detector exits", det_ext - base_x, 3);
    chk("loop enter_sent", 32'(ent0), 5);
    chk("loop exit_sent", 32'(ext0), 3);

    // Counter wrap at CNT_W=2
    for (int i = 0; i < 5; i++) begin
      issue(1, 1'b0);
      wait_idle(1);
      chk($sformatf("wrap enter_sent %0d", i + 1), 32'(ent1), 32'(wrap_tab[i]));
    end

    // Random traffic with occasional resets
    for (int i = 0; i < 4000; i++) begin
      rst   = ($urandom_range(0, 599) == 0);
      st[0] = ($urandom_range(0, 2) == 0);
      st[1] = ($urandom_range(0, 3) == 0);
      dr    = 2'($urandom_range(0, 3));
      tick();
    end
    rst = 1'b0;
    st  = 2'b00;
    repeat (20) tick();

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
